pps_sync_gen: RTL

- Disciplined PPS stage between the board PPS input pin and the PPS output pin inside the FTop timebase.
- Synchronizes the raw external PPS and measures its period in CLK cycles.
- Qualifies the PPS against a nominal period and regenerates a clean, fixed-width ppsOut phase-aligned to it.
- Free-runs in holdover when the reference disappears.

---
 rtl/pps_sync_gen_if.sv | 33 +++
 rtl/pps_sync_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pps_sync_gen_if.sv
// PPS stage signal bundle: control/input from the timebase,
// regenerated PPS and status back.
interface pps_sync_gen_if #(
  parameter int unsigned CNT_W = 32
);
  logic             enable;
  logic             pps_in;
  logic             ppsOut;
  logic             pps_strobe;
  logic             locked;
  logic             holdover;
  logic [CNT_W-1:0] period_last;

  modport master (
    output enable,
    output pps_in,
    input  ppsOut,
    input  pps_strobe,
    input  locked,
    input  holdover,
    input  period_last
  );

  modport slave (
    input  enable,
    input  pps_in,
    output ppsOut,
    output pps_strobe,
    output locked,
    output holdover,
    output period_last
  );
endinterface

// File: rtl/pps_sync_gen.sv
// Disciplined PPS: sync + period measure, lock qualification,
// phase-aligned fixed-width regeneration with holdover.
module pps_sync_gen #(
  parameter int unsigned CLK_HZ    = 125000000,
  parameter int unsigned TOL       = 1000,
  parameter int unsigned PULSE_LEN = 12500000,
  parameter int unsigned LOCK_N    = 2,
  parameter int unsigned HOLD_MAX  = 60,
  parameter int unsigned CNT_W     = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  pps_sync_gen_if.slave bus
);

  typedef enum logic [1:0] {
    UNLOCKED, ACQUIRE, LOCKED, HOLDOVER
  } state_e;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] PH_MAX = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] P_LO   = CNT_W'(CLK_HZ - TOL);
  localparam logic [CNT_W-1:0] P_HI   = CNT_W'(CLK_HZ + TOL);
  localparam logic [CNT_W-1:0] TOL_C  = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(PULSE_LEN);
  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_N);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MAX);

  state_e           state_q, state_d;
  logic             s1_q, s2_q, p_q;
  logic [CNT_W-1:0] cnt_q, per_q;
  logic [CNT_W-1:0] ph_q, ph_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] hsec_q, hsec_d;
  logic             pps_q, pps_d;
  logic             stb_q, stb_d;
  logic             realign, run_d;

  logic             rise, valid, tmo, wrap, near;
  logic [CNT_W-1:0] cnt_inc, ph_inc;

  assign rise    = s2_q & ~p_q;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + ONE;
  assign valid   = rise & (cnt_inc >= P_LO) & (cnt_inc <= P_HI);
  assign tmo     = cnt_q >= P_HI;
  assign wrap    = ph_q == PH_MAX;
  assign ph_inc  = wrap ? '0 : ph_q + ONE;
  // holdover recovery window straddles the expected edge
  assign near    = (ph_q <= TOL_C) | (ph_q >= P_LO);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= UNLOCKED;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      p_q     <= 1'b0;
      cnt_q   <= '0;
      per_q   <= '0;
      ph_q    <= '0;
      good_q  <= '0;
      hsec_q  <= '0;
      pps_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= bus.pps_in;
      s2_q    <= s1_q;
      p_q     <= s2_q;
      if (rise) begin
        per_q <= cnt_inc;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_inc;
      end
      ph_q    <= ph_d;
      good_q  <= good_d;
      hsec_q  <= hsec_d;
      pps_q   <= pps_d;
      stb_q   <= stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = '0;
    good_d  = good_q;
    hsec_d  = hsec_q;
    realign = 1'b0;
    if (!bus.enable) begin
      state_d = UNLOCKED;
      good_d  = '0;
      hsec_d  = '0;
    end else begin
      unique case (state_q)
        UNLOCKED: begin
          if (rise) begin
            state_d = ACQUIRE;
            good_d  = '0;
          end
        end
        ACQUIRE: begin
          if (valid) begin
            good_d = good_q + ONE;
            if (good_q + ONE == LOCK_C) begin
              state_d = LOCKED;
              realign = 1'b1;
            end
          end else if (rise) begin
            good_d = '0;
          end else if (tmo) begin
            state_d = UNLOCKED;
          end
        end
        LOCKED: begin
          ph_d = ph_inc;
          if (valid) begin
            ph_d    = '0;
            realign = 1'b1;
          end else if (rise) begin
            state_d = ACQUIRE;
            good_d  = '0;
            ph_d    = '0;
          end else if (tmo) begin
            state_d = HOLDOVER;
            hsec_d  = '0;
          end
        end
        HOLDOVER: begin
          ph_d = ph_inc;
          if (rise & near) begin
            state_d = LOCKED;
            ph_d    = '0;
            realign = 1'b1;
          end else if (wrap) begin
            hsec_d = hsec_q + ONE;
            if (hsec_q + ONE == HOLD_C) begin
              state_d = UNLOCKED;
              ph_d    = '0;
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  always_comb begin
    run_d = (state_d == LOCKED) | (state_d == HOLDOVER);
    pps_d = run_d & (ph_d < LEN_C);
    stb_d = run_d & (ph_d == '0) & (realign | wrap);
  end

  assign bus.ppsOut      = pps_q;
  assign bus.pps_strobe  = stb_q;
  assign bus.locked      = state_q == LOCKED;
  assign bus.holdover    = state_q == HOLDOVER;
  assign bus.period_last = per_q;

endmodule
